// File: rtl/sync_down_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload mode and a one-cycle terminal-count pulse.
// Optional sticky overrun flag for loads rejected while running: define SYNC_DOWN_OVERRUN_EN.
module sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             en,
    input  logic             abort,
    output logic             load_ready,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             tc
`ifdef SYNC_DOWN_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    stateT            r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_tc;

    stateT            w_nextState;
    logic [WIDTH-1:0] w_nextCount;
    logic [WIDTH-1:0] w_nextReload;
    logic             w_nextMode;
    logic             w_nextTc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_reload <= w_nextReload;
            r_mode   <= w_nextMode;
            r_tc     <= w_nextTc;
        end
    end

    // Abort outranks both enable and a same-cycle expiry, so it is tested first in RUN.
    always_comb begin
        w_nextState  = r_state;
        w_nextCount  = r_count;
        w_nextReload = r_reload;
        w_nextMode   = r_mode;
        w_nextTc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_nextCount  = load_value;
                    w_nextReload = load_value;
                    w_nextMode   = auto_reload;
                    if (load_value != '0) begin
                        w_nextState = RUN;
                    end else begin
                        w_nextTc = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    w_nextCount = '0;
                    w_nextState = IDLE;
                end else if (en) begin
                    if (r_count > ONE) begin
                        w_nextCount = r_count - ONE;
                    end else begin
                        w_nextTc = 1'b1;
                        if (r_mode) begin
                            w_nextCount = r_reload;
                        end else begin
                            w_nextCount = '0;
                            w_nextState = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state == RUN);
    assign count      = r_count;
    assign tc         = r_tc;

`ifdef SYNC_DOWN_OVERRUN_EN
    logic r_overrun;
    logic w_nextOverrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_nextOverrun;
        end
    end

    // A rejected request in RUN sets the flag; abort or an accepted load clears it.
    always_comb begin
        w_nextOverrun = r_overrun;
        if (r_state == RUN) begin
            if (abort) begin
                w_nextOverrun = 1'b0;
            end else if (load_valid) begin
                w_nextOverrun = 1'b1;
            end
        end else if (load_valid) begin
            w_nextOverrun = 1'b0;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule
